// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester command bus plus RAM port signals for ram_port_arbiter.
interface ram_port_arbiter_if #(parameter int NR = 4, parameter int DW = 8, parameter int AW = 6);
    logic [NR-1:0]    req;
    logic [NR-1:0]    lk;
    logic [NR-1:0]    we;
    logic [NR*AW-1:0] a;
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    vld;
    logic [DW-1:0]    q;
    logic             m_wr;
    logic [AW-1:0]    m_a;
    logic [DW-1:0]    m_d;
    logic [DW-1:0]    m_q;
    modport slave (input req, lk, we, a, d, m_q, output gnt, vld, q, m_wr, m_a, m_d);
    modport master (output req, lk, we, a, d, m_q, input gnt, vld, q, m_wr, m_a, m_d);
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one RAM port among NR requesters, with lock and read return.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module ram_port_arbiter #(parameter int NR = 4, parameter int DW = 8, parameter int AW = 6) (
    input logic i_clk,
    input logic i_rst,
    ram_port_arbiter_if.slave bus
);
    localparam int PW = (NR > 1) ? $clog2(NR) : 1;
    logic [PW-1:0] r_ptr, r_own, r_rdi, w_win, w_sel, w_idx;
    logic          r_lkd, r_rdv, w_any;
    // A lock only binds while its owner is still requesting; otherwise normal arbitration resumes.
    always_comb begin
        w_win = r_ptr;
        w_any = 1'b0;
        w_idx = '0;
        if (r_lkd && bus.req[r_own]) begin
            w_win = r_own;
            w_any = 1'b1;
        end else begin
            for (int k = 0; k < NR; k++) begin
                w_idx = PW'((int'(r_ptr) + k) % NR);
                if (!w_any && bus.req[w_idx]) begin
                    w_win = w_idx;
                    w_any = 1'b1;
                end
            end
        end
        if (i_rst) w_any = 1'b0;
        w_sel = w_any ? w_win : r_ptr;
    end
    assign bus.gnt  = w_any ? (NR'(1) << w_win) : '0;
    assign bus.m_wr = w_any & bus.we[w_win];
    assign bus.m_a  = bus.a[int'(w_sel)*AW +: AW];
    assign bus.m_d  = bus.d[int'(w_sel)*DW +: DW];
    assign bus.vld  = r_rdv ? (NR'(1) << r_rdi) : '0;
    assign bus.q    = bus.m_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
            r_lkd <= 1'b0;
            r_own <= '0;
            r_rdv <= 1'b0;
            r_rdi <= '0;
        end else begin
            r_lkd <= w_any & bus.lk[w_win];
            if (w_any & bus.lk[w_win]) r_own <= w_win;
            r_rdv <= w_any & ~bus.we[w_win];
            if (w_any) r_rdi <= w_win;
`ifdef ARB_FIXED_PRIO_EN
            r_ptr <= '0;
`else
            if (w_any) r_ptr <= (int'(w_win) == NR-1) ? '0 : w_win + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench with a RAM model and a rule-level arbitration reference model.
module tb_ram_port_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 6;
    typedef struct {int due; int id; logic [DW-1:0] dat;} exp_t;
    logic clk = 0;
    logic rst = 1;
    int n_tests = 0, n_fail = 0, cyc = 0, last_w = -1;
    int m_ptr = 0, m_own = 0;
    bit m_lkd = 0, mon_en = 0;
    exp_t sb[$];
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] shadow [2**AW];
    ram_port_arbiter_if #(.NR(NR), .DW(DW), .AW(AW)) bus();
    ram_port_arbiter #(.NR(NR), .DW(DW), .AW(AW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (bus.m_wr) mem[bus.m_a] <= bus.m_d;
        bus.m_q <= mem[bus.m_a];
    end
    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction
    // Monitor: any VLD must match the oldest outstanding read due this cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("vld", 32'(bus.vld), 32'(1) << sb[0].id);
                chk("q", 32'(bus.q), 32'(sb[0].dat));
                void'(sb.pop_front());
            end else chk("vld_idle", 32'(bus.vld), 0);
        end
    end
    task automatic set_cmd(int i, bit w, int ad, int dt, bit l);
        bus.req[i] = 1'b1;
        bus.we[i] = w;
        bus.lk[i] = l;
        bus.a[i*AW +: AW] = AW'(ad);
        bus.d[i*DW +: DW] = DW'(dt);
    endtask
    task automatic step(bit rst_late = 0);
        int w, s;
        @(negedge clk);
        w = -1;
        if (!rst) begin
            if (m_lkd && bus.req[m_own]) w = m_own;
            else for (int k = 0; k < NR; k++) begin
                s = (m_ptr + k) % NR;
                if (w < 0 && bus.req[s]) w = s;
            end
        end
        chk("gnt", 32'(bus.gnt), (w < 0) ? 0 : (32'(1) << w));
        chk("m_wr", 32'(bus.m_wr), (w < 0) ? 0 : 32'(bus.we[w]));
        if (!rst) begin
            s = (w < 0) ? m_ptr : w;
            chk("m_a", 32'(bus.m_a), 32'(bus.a[s*AW +: AW]));
            chk("m_d", 32'(bus.m_d), 32'(bus.d[s*DW +: DW]));
        end
        if (rst) begin
            m_ptr = 0; m_lkd = 0; m_own = 0;
        end else if (w >= 0) begin
            s = int'(bus.a[w*AW +: AW]);
            if (bus.we[w]) shadow[s] = bus.d[w*DW +: DW];
            else sb.push_back('{cyc + 1, w, shadow[s]});
`ifdef ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (w + 1) % NR;
`endif
            m_lkd = bus.lk[w];
            if (bus.lk[w]) m_own = w;
        end else m_lkd = 0;
        last_w = w;
        if (rst_late) begin
            #1 rst = 1;
            sb.delete();
            m_ptr = 0; m_lkd = 0; m_own = 0;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic clr();
        bus.req = '0;
        bus.lk = '0;
    endtask
    task automatic do_reset();
        rst = 1;
        clr();
        step();
        step();
        rst = 0;
    endtask
    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        mem[5] = 8'h3C;
        for (int i = 0; i < 2**AW; i++) shadow[i] = mem[i];
        bus.req = '1; bus.lk = '0; bus.we = '0; bus.a = '0; bus.d = '0;
        step();
        mon_en = 1;
        step();
        rst = 0;
        clr();
        set_cmd(0, 0, 5, 0, 0);
        step();
        clr();
        step();
        do_reset();
        for (int i = 0; i < NR; i++) set_cmd(i, 0, 10 + i, 0, 0);
        repeat (5) step();
        clr();
        step();
        do_reset();
        set_cmd(2, 0, 20, 0, 1);
        step();
        set_cmd(0, 0, 21, 0, 0);
        repeat (2) step();
        bus.lk[2] = 0;
        step();
        bus.req[2] = 0;
        step();
        clr();
        step();
        do_reset();
        set_cmd(1, 1, 9, 8'hA5, 0);
        step();
        clr();
        set_cmd(3, 0, 9, 0, 0);
        step();
        clr();
        repeat (2) step();
        do_reset();
        set_cmd(2, 0, 30, 0, 1);
        step(1);
        clr();
        step();
        rst = 0;
        set_cmd(1, 0, 31, 0, 0);
        set_cmd(2, 0, 32, 0, 0);
        step();
        clr();
        step();
`ifdef ARB_FIXED_PRIO_EN
        do_reset();
        set_cmd(0, 0, 40, 0, 0);
        set_cmd(2, 0, 41, 0, 0);
        repeat (4) step();
        bus.req[0] = 0;
        step();
        clr();
        step();
`endif
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++)
                if (!bus.req[i] && $urandom_range(1) == 1)
                    set_cmd(i, $urandom_range(1) == 1, $urandom_range(15), $urandom, $urandom_range(3) == 0);
            step();
            if (last_w >= 0) bus.req[last_w] = 0;
        end
        clr();
        repeat (3) step();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one port of the dual-port RAM among NR requesters on a single clock. It accepts one read or write command per cycle from the winning requester, drives the RAM port, and routes registered read data back with a per-requester valid strobe. An optional lock lets one requester own the port for back-to-back bursts. It sits between client engines and one RAM port; the other RAM port stays free for an independent consumer.

## Interface
Parameters:
- NR, 4, number of requesters (2..8)
- DW, 8, data width; equals the RAM DW
- AW, 6, address width; equals the RAM AW

Ports:
- C  in  1  clock; the RAM port clock is the same net
- R  in  1  reset, synchronous, active-high
- REQ  in  NR  per-requester command request
- LK  in  NR  per-requester lock; sampled only with a granted REQ
- WE  in  NR  per-requester write enable (1 = write, 0 = read)
- A  in  NR*AW  per-requester address; slice i = A[i*AW +: AW]
- D  in  NR*DW  per-requester write data, sliced as A
- GNT  out  NR  one-hot; command of requester i is accepted this cycle
- VLD  out  NR  one-hot; read data for requester i is on Q this cycle
- Q  out  DW  read data, shared by all requesters
- mWR  out  1  to RAM WR
- mA  out  AW  to RAM A
- mD  out  DW  to RAM D
- mQ  in  DW  from RAM Q (registered in the RAM, 1-cycle latency)

## Operation
- State: round-robin pointer PTR (0..NR-1), lock flag LKD, lock owner OWN, and a registered read tag (RDV, RDI).
- Arbitration is combinational within the cycle. Winner = first i with REQ[i]=1, scanning PTR, PTR+1, …, NR-1, 0, …, wrapping modulo NR.
- While LKD=1, only OWN can win. Other requests are ignored and keep waiting; they are not dropped.
- GNT[winner]=1 only when some REQ bit is 1. With no request, GNT=0 and mWR=0.
- mWR = WE[winner]&grant, mA = A slice of winner, mD = D slice of winner. With no grant, mA/mD hold the slice of requester PTR, and mWR=0.
- On each grant: PTR <= winner+1 (wrapping NR-1 -> 0).
- Lock: a grant with LK[winner]=1 sets LKD=1 and OWN=winner. LKD clears on the first cycle OWN has REQ=0, or on a granted command with LK=0. PTR still advances on locked grants, so OWN goes last in rotation after release.
- Read return: a granted read sets RDV<=1 and RDI<=winner. A write or no grant sets RDV<=0. VLD = RDV ? onehot(RDI) : 0. Q = mQ, passed through without a register.
- Writes produce no VLD. A requester sees completion of a write only through GNT.
- Requesters hold REQ/WE/A/D/LK stable until they see GNT. They may change them on the cycle after GNT.

## Timing
- Reset (R=1 at posedge C): PTR=0, LKD=0, OWN=0, RDV=0. The next cycle has VLD=0. GNT follows REQ combinationally; GNT and mWR are 0 while R=1.
- A grant in cycle n puts the command on the RAM port in cycle n; the RAM samples it at the end of cycle n.
- For a read granted in cycle n: VLD and Q are valid in cycle n+1 (1-cycle latency).
- Throughput is one command per cycle. Back-to-back reads from different requesters give back-to-back VLD pulses in grant order.
- A reset asserted with a read outstanding discards it: no VLD is issued after reset. Any lock is released.
- A read-after-write to the same address in consecutive grants returns the new data, because of the RAM's write-then-read ordering across edges.

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority, with requester 0 highest. PTR is held at 0 and never updated. The lock behaves as specified.
- Not defined: round-robin as specified under Operation.

## Test plan
- Reset, then REQ=4'b0001, WE=0, A0=5 with RAM[5]=8'h3C: GNT=0001 in cycle 0, then VLD=0001 and Q=8'h3C in cycle 1.
- REQ=4'b1111 held for 4 reads: GNT sequence 0001, 0010, 0100, 1000, then back to 0001. VLD follows one cycle later; Q in each cycle matches the granted address.
- Requester 2 asserts REQ+LK for 3 cycles while REQ[0] is held: GNT=0100 three times. LK drops on the 4th command, which is still granted to requester 2. The next grant goes to requester 0 (only 0 pending).
- Requester 1 writes A=9, D=8'hA5; next cycle requester 3 reads A=9: mWR=1 only in the first cycle, VLD=1000 with Q=8'hA5 in the cycle after the read grant, and no VLD for the write.
- Read granted to requester 2, R=1 on the next edge: VLD stays 0, PTR=0 afterwards, lock cleared.
- With ARB_FIXED_PRIO_EN and REQ=4'b0101 held: GNT=0001 every cycle, and requester 2 is starved until REQ[0] drops.
